// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, functs,
// ALU operation codes, FSM states and datapath mux selects.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXEC      = 4'd6,
        ALU_WB    = 4'd7,
        BR_CMP    = 4'd8,
        BR_ADDR   = 4'd9,
        BR_RES    = 4'd10,
        JUMP      = 4'd11,
        ADDI_EXEC = 4'd12,
        ADDI_WB   = 4'd13
    } state_e;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } src_b_e;

    typedef enum logic [1:0] {
        PCSRC_ALU  = 2'b00,
        PCSRC_JUMP = 2'b10
    } pc_src_e;

    // States that sit waiting on mem_ready and are covered by the timeout.
    function automatic logic is_mem_wait(input state_e s);
        return (s == FETCH) || (s == MEM_READ) || (s == MEM_WRITE);
    endfunction

endpackage

// File: rtl/mips_multicycle_control_alu_control.sv
// R-type funct decoder: maps funct to an ALU operation and flags unsupported functs.
module alu_control
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct_i,
    output alu_op_e    alu_op_o,
    output logic       valid_o
);

    always_comb begin
        alu_op_o = ALU_ADD;
        valid_o  = 1'b1;
        case (funct_i)
            FN_ADD:  alu_op_o = ALU_ADD;
            FN_SUB:  alu_op_o = ALU_SUB;
            FN_AND:  alu_op_o = ALU_AND;
            FN_OR:   alu_op_o = ALU_OR;
            FN_SLT:  alu_op_o = ALU_SLT;
            default: valid_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute and drives
// ALU, PC, IR, memory and register-file controls from opcode/funct.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 0,
    parameter int TMO_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] alu_operation,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic       pc_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal_op,
    output logic       mem_error,
    output logic       instr_done,
    output logic [3:0] state
);

    localparam logic [TMO_W-1:0] TMO_LAST =
        (MEM_TIMEOUT > 0) ? TMO_W'(MEM_TIMEOUT - 1) : '0;

    state_e           state_q, state_d;
    logic             take_q, take_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    alu_op_e          rtype_op;
    logic             rtype_valid;
    logic             tmo_hit;

    alu_control u_alu_control (
        .funct_i  (funct),
        .alu_op_o (rtype_op),
        .valid_o  (rtype_valid)
    );

    // Memory handshake: mem_read/mem_write hold steady while waiting; the access
    // completes in the cycle mem_ready is high, and ir_write/mdr_write fire in that
    // same cycle. mem_ready is ignored in every other state.
    assign tmo_hit = (MEM_TIMEOUT != 0) && is_mem_wait(state_q) && !mem_ready
                     && (tmo_cnt_q == TMO_LAST);

    always_comb begin
        state_d       = state_q;
        take_d        = take_q;
        alu_operation = ALU_AND;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        pc_source     = PCSRC_ALU;
        pc_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mdr_write     = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        illegal_op    = 1'b0;
        mem_error     = 1'b0;
        instr_done    = 1'b0;
        state         = state_q;

        case (state_q)
            FETCH: begin
                mem_read      = 1'b1;
                alu_operation = ALU_ADD;
                alu_src_b     = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = DECODE;
                end else if (tmo_hit) begin
                    mem_error = 1'b1;
                end
            end
            DECODE: begin
                // PC+4 was computed by the ALU during the final FETCH cycle.
                pc_write = 1'b1;
                case (opcode)
                    OP_RTYPE: begin
                        if (rtype_valid) begin
                            state_d = EXEC;
                        end else begin
                            illegal_op = 1'b1;
                            state_d    = FETCH;
                        end
                    end
                    OP_LW, OP_SW:   state_d = MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = BR_CMP;
                    OP_ADDI:        state_d = ADDI_EXEC;
                    OP_J:           state_d = JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                alu_operation = ALU_ADD;
                alu_src_a     = 1'b1;
                alu_src_b     = SRCB_IMM;
                state_d       = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                alu_operation = ALU_ADD;
                alu_src_a     = 1'b1;
                alu_src_b     = SRCB_IMM;
                i_or_d        = 1'b1;
                mem_read      = 1'b1;
                if (mem_ready) begin
                    mdr_write = 1'b1;
                    state_d   = MEM_WB;
                end else if (tmo_hit) begin
                    mem_error = 1'b1;
                    state_d   = FETCH;
                end
            end
            MEM_WRITE: begin
                alu_operation = ALU_ADD;
                alu_src_a     = 1'b1;
                alu_src_b     = SRCB_IMM;
                i_or_d        = 1'b1;
                mem_write     = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end else if (tmo_hit) begin
                    mem_error = 1'b1;
                    state_d   = FETCH;
                end
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            EXEC: begin
                alu_operation = rtype_op;
                alu_src_a     = 1'b1;
                state_d       = ALU_WB;
            end
            ALU_WB: begin
                alu_operation = rtype_op;
                alu_src_a     = 1'b1;
                reg_write     = 1'b1;
                reg_dst       = 1'b1;
                instr_done    = 1'b1;
                state_d       = FETCH;
            end
            BR_CMP: begin
                alu_operation = ALU_SUB;
                alu_src_a     = 1'b1;
                state_d       = BR_ADDR;
            end
            BR_ADDR: begin
                // zero now reflects the BR_CMP subtraction.
                alu_operation = ALU_ADD;
                alu_src_b     = SRCB_IMM_SH2;
                take_d        = (opcode == OP_BNE) ? ~zero : zero;
                state_d       = BR_RES;
            end
            BR_RES: begin
                pc_write   = take_q;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            ADDI_EXEC: begin
                alu_operation = ALU_ADD;
                alu_src_a     = 1'b1;
                alu_src_b     = SRCB_IMM;
                state_d       = ADDI_WB;
            end
            ADDI_WB: begin
                alu_operation = ALU_ADD;
                alu_src_a     = 1'b1;
                alu_src_b     = SRCB_IMM;
                reg_write     = 1'b1;
                instr_done    = 1'b1;
                state_d       = FETCH;
            end
            default: state_d = FETCH;
        endcase

        // Reset is synchronous, so the register may still hold a mid-instruction
        // state this cycle; suppress every output so nothing is written.
        if (reset) begin
            alu_operation = '0;
            alu_src_a     = 1'b0;
            alu_src_b     = '0;
            pc_source     = '0;
            pc_write      = 1'b0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mdr_write     = 1'b0;
            reg_write     = 1'b0;
            reg_dst       = 1'b0;
            mem_to_reg    = 1'b0;
            illegal_op    = 1'b0;
            mem_error     = 1'b0;
            instr_done    = 1'b0;
            state         = FETCH;
        end
    end

    always_comb begin
        tmo_cnt_d = '0;
        if (is_mem_wait(state_q) && (state_d == state_q) && !tmo_hit) begin
            tmo_cnt_d = (tmo_cnt_q == '1) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            take_q    <= 1'b0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            take_q    <= take_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

endmodule
